pwm_duty_ctrl: RTL and testbench
================================

Name: pwm_duty_ctrl

Overview:
Controller that sequences the duty cycle of the PWM generator from a raw push-button.
- Synchronises and debounces the key.
- Steps a target duty between configurable limits, with wrap-around at either end.
- Slews the applied duty one count per PWM period, so duty changes only at period boundaries and glitch-free.
- Owns the period counter and drives the pwm output directly; it sits between the board button/direction switch and the output pin.

Parameters:
CW, 7, width of counter and duty values.
PERIOD, 100, PWM period in clk cycles; counter runs 0..PERIOD-1.
DUTY_MIN, 10, lowest target/duty.
DUTY_MAX, 90, highest target/duty.
STEP, 10, target increment per accepted key press.
DB_CYCLES, 4, consecutive stable cycles required to accept a key level.

Parameter legality: 0 < DUTY_MIN <= DUTY_MAX <= PERIOD, STEP > 0, PERIOD <= 2^CW.

Ports:
clk  in  1  system clock
rst  in  1  reset
key  in  1  raw asynchronous push-button, active high
dir  in  1  step direction: 0 = up, 1 = down; sampled on key event
en  in  1  PWM enable
duty  out  CW  currently applied duty
target  out  CW  requested duty
busy  out  1  high while duty != target
period_end  out  1  one-cycle pulse on the last cycle of each period
pwm  out  1  PWM output, registered

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: cnt=0, duty=DUTY_MIN, target=DUTY_MIN, state=IDLE, synchroniser and debounce level=0, key_evt=0, pwm=0, period_end=0, busy=0.
- Key path:
  - key passes through a 2-FF synchroniser.
  - The debounce counter reloads whenever the synchronised level differs from the accepted level.
  - After DB_CYCLES consecutive differing cycles, the accepted level flips.
  - A 0->1 flip of the accepted level produces key_evt for exactly one cycle.
  - Latency from a clean key rise to key_evt is 2 + DB_CYCLES cycles.
  - Release is debounced identically and produces no event.
- Target update on key_evt, computed at CW+1 bits:
  - dir=0: target+STEP; if the result > DUTY_MAX, target=DUTY_MIN.
  - dir=1: if target < DUTY_MIN+STEP, target=DUTY_MAX; else target-STEP.
  - key_evt is honoured regardless of en and state.
- Period counter:
  - When en=1, cnt increments and wraps from PERIOD-1 to 0.
  - When en=0, cnt is forced to 0.
  - period_end = en & (cnt==PERIOD-1).
- Ramp FSM, states IDLE / RAMP_UP / RAMP_DN, evaluated only on period_end:
  - duty<target: duty+1, state RAMP_UP.
  - duty>target: duty-1, state RAMP_DN.
  - Otherwise: state IDLE.
  - Between boundaries, state reflects the comparison made at the last boundary.
  - busy = (duty != target), combinational from registers.
- Simultaneous key_evt and period_end: the duty step uses the old target; the new target takes effect at the next boundary.
- Target change mid-ramp: no restart; direction is re-evaluated at the next boundary, which may reverse the ramp.
- en deasserted mid-ramp: duty, target and state are held; pwm=0; cnt=0. On re-enable the ramp resumes, with the first boundary after PERIOD cycles.
- pwm:
  - pwm <= en & (cnt < duty), registered, so 1-cycle latency from cnt.
  - duty=PERIOD gives constant high; duty=0 is unreachable.
- Reset mid-operation: rst asserted in any cycle overrides all updates that cycle, including key_evt and period_end, and returns every register to its reset value.

Test Plan:
All scenarios use default parameters.
1. rst=1 for 2 cycles, then en=1, no key -> duty=10, target=10, busy=0; pwm high for 10 cycles then low for 90, repeating, delayed 1 cycle from cnt; period_end every 100 cycles.
2. key glitches of 1, 2 and 3 cycles -> target stays 10. key held 10 cycles with dir=0 -> target=20 exactly once, 6 cycles after the rise. Release then press again -> target=30.
3. target 10->20 -> busy=1; duty increments once per period_end (11, 12, ...); duty=20 after 10 periods; busy=0 and state IDLE at the following boundary.
4. Wrap: target=90, dir=0 press -> target=10, duty ramps down 80 periods. dir=1 press at target=10 -> target=90.
5. key_evt forced into the same cycle as period_end with duty=target=20, dir=0 -> duty stays 20 that boundary; target=30; duty=21 at the next boundary.
6. Mid-ramp at duty=15 -> en=0 for 250 cycles: pwm=0, duty held at 15. Re-enable: ramp continues. Then rst=1 for 1 cycle: duty=10, target=10, pwm=0 next cycle.

Source files
------------

// File: rtl/pwm_duty_ctrl_if.sv
// Board-side bundle for the PWM duty controller.
// The master drives the button, direction switch and enable.
// The slave returns the duty/target status and the PWM pin.
interface pwm_duty_ctrl_if #(
  parameter int CW = 7
);
  logic          key;
  logic          dir;
  logic          en;
  logic [CW-1:0] duty;
  logic [CW-1:0] target;
  logic          busy;
  logic          period_end;
  logic          pwm;

  modport master (
    output key, dir, en,
    input  duty, target, busy, period_end, pwm
  );

  modport slave (
    input  key, dir, en,
    output duty, target, busy, period_end, pwm
  );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// PWM duty controller.
// A debounced push-button steps a target duty between DUTY_MIN and DUTY_MAX,
// wrapping at either end. The applied duty slews one count per PWM period
// toward the target, so the waveform only changes at period boundaries.
module pwm_duty_ctrl #(
  parameter int CW        = 7,
  parameter int PERIOD    = 100,
  parameter int DUTY_MIN  = 10,
  parameter int DUTY_MAX  = 90,
  parameter int STEP      = 10,
  parameter int DB_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  pwm_duty_ctrl_if.slave bus
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0]  MIN_W    = CW'(DUTY_MIN);
  localparam logic [CW-1:0]  MAX_W    = CW'(DUTY_MAX);
  localparam logic [CW:0]    STEP_X   = (CW+1)'(STEP);
  localparam logic [CW:0]    MAX_X    = (CW+1)'(DUTY_MAX);
  localparam logic [CW:0]    DN_LIM_X = (CW+1)'(DUTY_MIN + STEP);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RAMP_UP = 2'd1;
  localparam logic [1:0] RAMP_DN = 2'd2;

  logic           key_meta_q;
  logic           key_sync_q;
  logic           db_level_q, db_level_d;
  logic [DBW-1:0] db_cnt_q,   db_cnt_d;
  logic           key_evt_q,  key_evt_d;
  logic [CW-1:0]  target_q,   target_d;
  logic [CW-1:0]  cnt_q,      cnt_d;
  logic [CW-1:0]  duty_q,     duty_d;
  logic [1:0]     state_q,    state_d;
  logic           pwm_q,      pwm_d;
  logic           period_end;

  logic [CW:0]    tgt_up;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
    end else begin
      key_meta_q <= bus.key;
      key_sync_q <= key_meta_q;
    end
  end

  // Debounce: accept a new level after DB_CYCLES consecutive disagreeing cycles;
  // only an accepted rising level produces a key event.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    key_evt_d  = 1'b0;
    if (key_sync_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = key_sync_q;
        key_evt_d  = key_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Target stepping with wrap-around; arithmetic at CW+1 bits so the
  // upward sum cannot overflow before it is compared against DUTY_MAX.
  assign tgt_up = {1'b0, target_q} + STEP_X;

  always_comb begin
    target_d = target_q;
    if (key_evt_q) begin
      if (!bus.dir) begin
        target_d = (tgt_up > MAX_X) ? MIN_W : tgt_up[CW-1:0];
      end else begin
        target_d = ({1'b0, target_q} < DN_LIM_X) ? MAX_W : CW'(target_q - CW'(STEP));
      end
    end
  end

  // Period counter; held at zero while disabled so re-enable starts a full period.
  always_comb begin
    cnt_d = '0;
    if (bus.en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign period_end = bus.en & (cnt_q == CNT_LAST);

  // Ramp FSM: at each boundary move duty one count toward target.
  // A key event in the same cycle only updates target, so this step
  // compares against the old target.
  always_comb begin
    duty_d  = duty_q;
    state_d = state_q;
    if (period_end) begin
      if (duty_q < target_q) begin
        duty_d  = duty_q + 1'b1;
        state_d = RAMP_UP;
      end else if (duty_q > target_q) begin
        duty_d  = duty_q - 1'b1;
        state_d = RAMP_DN;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // PWM compare; registered so the pin is glitch-free, one cycle behind cnt.
  assign pwm_d = bus.en & (cnt_q < duty_q);

  // Controller state registers; reset overrides every update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      key_evt_q  <= 1'b0;
      target_q   <= MIN_W;
      cnt_q      <= '0;
      duty_q     <= MIN_W;
      state_q    <= IDLE;
      pwm_q      <= 1'b0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      key_evt_q  <= key_evt_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      state_q    <= state_d;
      pwm_q      <= pwm_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.target     = target_q;
  assign bus.busy       = (duty_q != target_q);
  assign bus.period_end = period_end;
  assign bus.pwm        = pwm_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pwm_duty_ctrl;

  localparam int CW     = 7;
  localparam int PERIOD = 100;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  pwm_duty_ctrl_if #(.CW(CW)) bus ();

  pwm_duty_ctrl #(
    .CW(CW), .PERIOD(PERIOD), .DUTY_MIN(10), .DUTY_MAX(90), .STEP(10), .DB_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b0; bus.key = 1'b0; bus.dir = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic press(input logic d, input int hold, input int gap);
    bus.dir = d; bus.key = 1'b1;
    tick(hold);
    bus.key = 1'b0;
    tick(gap);
  endtask

  // Advance to the next falling edge on which period_end is high (bounded).
  task automatic wait_pe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (bus.period_end) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  // Follow duty one count per boundary from 'from' to 'to'.
  task automatic ramp_track(input int from, input int to, input string name);
    int exp  = from;
    int errs = 0;
    bit ok;
    while (exp != to) begin
      wait_pe(ok);
      if (!ok) begin errs++; break; end
      tick(1);
      exp += (to > exp) ? 1 : -1;
      if (bus.duty !== CW'(exp)) errs++;
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s: duty=%0d, required %0d (%0d bad steps)", name, bus.duty, exp, errs);
    end
  endtask

  task automatic test_reset();
    int pwm_err = 0, pe_err = 0, pe_cnt = 0, hi_cnt = 0;
    logic exp_pwm, exp_pe;
    do_reset();
    n_checks++;
    if (bus.duty !== 7'd10) begin n_fail++; $display("FAIL reset_duty: got %0d, required 10", bus.duty); end
    n_checks++;
    if (bus.target !== 7'd10) begin n_fail++; $display("FAIL reset_target: got %0d, required 10", bus.target); end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.pwm !== 1'b0 || bus.period_end !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b pwm=%b pe=%b, required 0 0 0", bus.busy, bus.pwm, bus.period_end);
    end
    n_checks++;
    if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", dut.state_q); end
    bus.en = 1'b1;
    for (int k = 1; k <= 250; k++) begin
      tick(1);
      exp_pwm = ((k - 1) % PERIOD) < 10;
      exp_pe  = (k % PERIOD) == PERIOD - 1;
      if (bus.pwm !== exp_pwm) pwm_err++;
      if (bus.period_end !== exp_pe) pe_err++;
      if (bus.period_end === 1'b1) pe_cnt++;
      if (bus.pwm === 1'b1) hi_cnt++;
    end
    n_checks++;
    if (pwm_err != 0) begin n_fail++; $display("FAIL pwm_pattern: %0d wrong cycles, required 0", pwm_err); end
    n_checks++;
    if (pe_err != 0) begin n_fail++; $display("FAIL period_end_pattern: %0d wrong cycles, required 0", pe_err); end
    n_checks++;
    if (pe_cnt != 2 || hi_cnt != 30) begin
      n_fail++; $display("FAIL pwm_counts: pe=%0d high=%0d, required 2 30", pe_cnt, hi_cnt);
    end
  endtask

  task automatic test_debounce();
    int evt_cnt = 0, evt_at = -1;
    logic [CW-1:0] tgt6 = '0, tgt7 = '0;
    do_reset();
    for (int g = 1; g <= 3; g++) begin
      bus.key = 1'b1; tick(g);
      bus.key = 1'b0; tick(10);
      n_checks++;
      if (bus.target !== 7'd10) begin n_fail++; $display("FAIL glitch_%0d: target=%0d, required 10", g, bus.target); end
    end
    bus.dir = 1'b0; bus.key = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (dut.key_evt_q === 1'b1) begin evt_cnt++; evt_at = i; end
      if (i == 6) tgt6 = bus.target;
      if (i == 7) tgt7 = bus.target;
    end
    n_checks++;
    if (evt_cnt != 1 || evt_at != 6) begin
      n_fail++; $display("FAIL key_evt_latency: %0d events at cycle %0d, required 1 at 6", evt_cnt, evt_at);
    end
    n_checks++;
    if (tgt6 !== 7'd10 || tgt7 !== 7'd20) begin
      n_fail++; $display("FAIL first_press: target %0d then %0d, required 10 then 20", tgt6, tgt7);
    end
    bus.key = 1'b0; tick(15);
    n_checks++;
    if (bus.target !== 7'd20) begin n_fail++; $display("FAIL release: target=%0d, required 20", bus.target); end
    press(1'b0, 10, 10);
    n_checks++;
    if (bus.target !== 7'd30) begin n_fail++; $display("FAIL second_press: target=%0d, required 30", bus.target); end
  endtask

  task automatic test_ramp();
    bit ok;
    do_reset();
    bus.en = 1'b1;
    press(1'b0, 10, 5);
    n_checks++;
    if (bus.target !== 7'd20 || bus.duty !== 7'd10 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL ramp_start: target=%0d duty=%0d busy=%b, required 20 10 1", bus.target, bus.duty, bus.busy);
    end
    ramp_track(10, 20, "ramp_up");
    n_checks++;
    if (bus.busy !== 1'b0 || dut.state_q !== 2'd1) begin
      n_fail++; $display("FAIL ramp_done: busy=%b state=%0d, required 0 1", bus.busy, dut.state_q);
    end
    wait_pe(ok);
    tick(1);
    n_checks++;
    if (!ok || dut.state_q !== 2'd0 || bus.duty !== 7'd20) begin
      n_fail++; $display("FAIL ramp_idle: ok=%b state=%0d duty=%0d, required 1 0 20", ok, dut.state_q, bus.duty);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) press(1'b0, 10, 5);
    n_checks++;
    if (bus.target !== 7'd90) begin n_fail++; $display("FAIL step_to_max: target=%0d, required 90", bus.target); end
    bus.en = 1'b1;
    ramp_track(10, 90, "ramp_to_90");
    press(1'b0, 10, 5);
    n_checks++;
    if (bus.target !== 7'd10 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL wrap_up: target=%0d busy=%b, required 10 1", bus.target, bus.busy);
    end
    ramp_track(90, 10, "ramp_wrap_down");
    n_checks++;
    if (dut.state_q !== 2'd2) begin n_fail++; $display("FAIL ramp_dn_state: got %0d, required 2", dut.state_q); end
    press(1'b1, 10, 5);
    n_checks++;
    if (bus.target !== 7'd90) begin n_fail++; $display("FAIL wrap_down: target=%0d, required 90", bus.target); end
    press(1'b1, 10, 5);
    n_checks++;
    if (bus.target !== 7'd80) begin n_fail++; $display("FAIL step_down: target=%0d, required 80", bus.target); end
  endtask

  task automatic test_coincide();
    bit ok;
    do_reset();
    bus.en = 1'b1;
    press(1'b0, 10, 5);
    ramp_track(10, 20, "coincide_setup");
    wait_pe(ok);
    tick(94);
    bus.dir = 1'b0; bus.key = 1'b1;
    tick(6);
    n_checks++;
    if (!ok || bus.period_end !== 1'b1 || dut.key_evt_q !== 1'b1) begin
      n_fail++; $display("FAIL coincide_align: pe=%b evt=%b, required 1 1", bus.period_end, dut.key_evt_q);
    end
    tick(1);
    n_checks++;
    if (bus.duty !== 7'd20 || bus.target !== 7'd30) begin
      n_fail++; $display("FAIL coincide_step: duty=%0d target=%0d, required 20 30", bus.duty, bus.target);
    end
    tick(3);
    bus.key = 1'b0;
    wait_pe(ok);
    tick(1);
    n_checks++;
    if (!ok || bus.duty !== 7'd21) begin n_fail++; $display("FAIL coincide_next: duty=%0d, required 21", bus.duty); end
  endtask

  task automatic test_enable_reset();
    int errs = 0;
    int wait_cycles = -1;
    do_reset();
    bus.en = 1'b1;
    press(1'b0, 10, 5);
    ramp_track(10, 15, "ramp_to_15");
    bus.en = 1'b0;
    tick(1);
    for (int i = 0; i < 250; i++) begin
      if (bus.pwm !== 1'b0 || bus.period_end !== 1'b0 || bus.duty !== 7'd15) errs++;
      tick(1);
    end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL disabled_hold: %0d wrong cycles, required 0", errs); end
    n_checks++;
    if (bus.target !== 7'd20 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL disabled_target: target=%0d busy=%b, required 20 1", bus.target, bus.busy);
    end
    bus.en = 1'b1;
    for (int i = 0; i <= 2 * PERIOD; i++) begin
      if (bus.period_end) begin wait_cycles = i; break; end
      tick(1);
    end
    n_checks++;
    if (wait_cycles != PERIOD - 1) begin
      n_fail++; $display("FAIL reenable_boundary: after %0d cycles, required %0d", wait_cycles, PERIOD - 1);
    end
    tick(1);
    n_checks++;
    if (bus.duty !== 7'd16) begin n_fail++; $display("FAIL reenable_resume: duty=%0d, required 16", bus.duty); end
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (bus.duty !== 7'd10 || bus.target !== 7'd10 || bus.pwm !== 1'b0 || bus.busy !== 1'b0 || dut.state_q !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: duty=%0d target=%0d pwm=%b busy=%b state=%0d, required 10 10 0 0 0",
               bus.duty, bus.target, bus.pwm, bus.busy, dut.state_q);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.key = 1'b0; bus.dir = 1'b0;
    test_reset();
    test_debounce();
    test_ramp();
    test_wrap();
    test_coincide();
    test_enable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
